// File: rtl/sbqm_pkg.sv
// sbqm_pkg: shared widths and pass-detect state encoding for the bank queue manager.
package sbqm_pkg;
  localparam int PC_W = 3;
  localparam int TC_W = 2;
  localparam int MAX_PC = 2**PC_W - 1;
  typedef enum logic [1:0] {IDLE, BLOCKED, VALID} pd_state_e;
endpackage

// File: rtl/queue_counter_if.sv
// queue_counter_if: sensor/teller inputs and occupancy/status outputs of the queue counter.
interface queue_counter_if #(parameter int PC_W = sbqm_pkg::PC_W);
  logic sens_back;
  logic sens_front;
  logic [sbqm_pkg::TC_W-1:0] tcount;
  logic [sbqm_pkg::TC_W-1:0] tc_out;
  logic [PC_W-1:0] pcount;
  logic full;
  logic empty;
  logic ovf_err;
  logic unf_err;
  logic tc_err;
  modport master (output sens_back, sens_front, tcount,
                  input pcount, tc_out, full, empty, ovf_err, unf_err, tc_err);
  modport slave (input sens_back, sens_front, tcount,
                 output pcount, tc_out, full, empty, ovf_err, unf_err, tc_err);
endinterface

// File: rtl/queue_counter_pass_detect.sv
// sensor_pass_detect: synchronizes one photocell and pulses pass_o after a blockage of at least MIN_BLK cycles ends.
module sensor_pass_detect
  import sbqm_pkg::*;
#(
  parameter int MIN_BLK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sens_i,
  output logic pass_o
);
  localparam int CW = $clog2(MIN_BLK + 1);
  localparam logic [CW-1:0] LIM = CW'(MIN_BLK);
  logic s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  pd_state_e state_q, state_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      s1_q <= sens_i;
      s2_q <= s1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // count saturates at MIN_BLK so a long blockage simply holds VALID
  always_comb begin
    cnt_d = !s2_q ? '0 : (state_q == IDLE) ? CW'(1) : (cnt_q == LIM) ? cnt_q : cnt_q + CW'(1);
    state_d = !s2_q ? IDLE : (cnt_d == LIM || state_q == VALID) ? VALID : BLOCKED;
  end
  always_comb pass_o = (state_q == VALID) && !s2_q;
endmodule

// File: rtl/queue_counter.sv
// queue_counter: counts complete entry/exit passes into a saturating occupancy count with status and error flags.
module queue_counter #(
  parameter int PC_W = 3,
  parameter int MIN_BLK = 4
) (
  input  logic clk,
  input  logic rst_n,
  queue_counter_if.slave qc
);
  import sbqm_pkg::*;
  localparam logic [PC_W-1:0] MAX = {PC_W{1'b1}};
  logic pass_back, pass_front, inc, dec;
  logic [PC_W-1:0] pcount_q, pcount_d;
  logic [TC_W-1:0] tc_q;
  logic full_q, empty_q, ovf_q, unf_q, tc_err_q;
  sensor_pass_detect #(.MIN_BLK(MIN_BLK)) u_back (
    .clk(clk), .rst_n(rst_n), .sens_i(qc.sens_back), .pass_o(pass_back)
  );
  sensor_pass_detect #(.MIN_BLK(MIN_BLK)) u_front (
    .clk(clk), .rst_n(rst_n), .sens_i(qc.sens_front), .pass_o(pass_front)
  );
  // simultaneous entry and exit cancel, even at the full/empty limits
  always_comb begin
    inc = pass_back && !pass_front;
    dec = pass_front && !pass_back;
    pcount_d = (inc && pcount_q != MAX) ? pcount_q + 1'b1 :
               (dec && pcount_q != '0) ? pcount_q - 1'b1 : pcount_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcount_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      tc_q <= '0;
      tc_err_q <= 1'b1;
    end else begin
      pcount_q <= pcount_d;
      full_q <= pcount_d == MAX;
      empty_q <= pcount_d == '0;
      ovf_q <= inc && pcount_q == MAX;
      unf_q <= dec && pcount_q == '0;
      tc_q <= qc.tcount;
      tc_err_q <= qc.tcount == '0;
    end
  end
  assign qc.pcount = pcount_q;
  assign qc.full = full_q;
  assign qc.empty = empty_q;
  assign qc.ovf_err = ovf_q;
  assign qc.unf_err = unf_q;
  assign qc.tc_out = tc_q;
  assign qc.tc_err = tc_err_q;
endmodule

// File: tb/tb_queue_counter.sv
// tb_queue_counter: random and directed sensor traffic checked every cycle against a run-length occupancy model.
module tb_queue_counter;
  import sbqm_pkg::*;
  localparam int MIN_BLK = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  queue_counter_if #(.PC_W(PC_W)) qc();
  queue_counter #(.PC_W(PC_W), .MIN_BLK(MIN_BLK)) dut (.clk(clk), .rst_n(rst_n), .qc(qc));
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, n_ovf = 0, n_unf = 0;
  int m_pc = 0, m_tc = 0;
  int m_run [2] = '{0, 0};
  bit m_s1 [2] = '{0, 0};
  bit m_s2 [2] = '{0, 0};
  bit m_ovf = 0, m_unf = 0, m_tcerr = 1, started = 0, pb, pf;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // model: a pass is a synchronized blockage whose high run reached MIN_BLK, seen the cycle it drops
  always @(posedge clk) begin
    started = 1;
    if (!rst_n) begin
      m_pc = 0; m_tc = 0; m_tcerr = 1; m_ovf = 0; m_unf = 0;
      m_run = '{0, 0}; m_s1 = '{0, 0}; m_s2 = '{0, 0};
    end else begin
      pb = !m_s2[0] && m_run[0] >= MIN_BLK;
      pf = !m_s2[1] && m_run[1] >= MIN_BLK;
      m_ovf = pb && !pf && m_pc == MAX_PC;
      m_unf = pf && !pb && m_pc == 0;
      if (pb && !pf && m_pc < MAX_PC) m_pc++;
      if (pf && !pb && m_pc > 0) m_pc--;
      for (int i = 0; i < 2; i++) m_run[i] = m_s2[i] ? m_run[i] + 1 : 0;
      m_s2 = m_s1;
      m_s1 = '{qc.sens_back, qc.sens_front};
      m_tc = int'(qc.tcount);
      m_tcerr = qc.tcount == 0;
    end
  end
  always @(negedge clk) if (started) begin
    chk("pcount", 32'(qc.pcount), m_pc);
    chk("full", 32'(qc.full), 32'(m_pc == MAX_PC));
    chk("empty", 32'(qc.empty), 32'(m_pc == 0));
    chk("ovf_err", 32'(qc.ovf_err), 32'(m_ovf));
    chk("unf_err", 32'(qc.unf_err), 32'(m_unf));
    chk("tc_out", 32'(qc.tc_out), m_tc);
    chk("tc_err", 32'(qc.tc_err), 32'(m_tcerr));
    if (qc.ovf_err === 1'b1) n_ovf++;
    if (qc.unf_err === 1'b1) n_unf++;
  end
  task automatic pulse(input bit b, input bit f, input int len);
    qc.sens_back = b;
    qc.sens_front = f;
    repeat (len) @(negedge clk);
    qc.sens_back = 1'b0;
    qc.sens_front = 1'b0;
    repeat (6) @(negedge clk);
  endtask
  int o, u, hb, hf;
  initial begin
    qc.sens_back = 1'b0;
    qc.sens_front = 1'b0;
    qc.tcount = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_pcount", 32'(qc.pcount), 0);
    chk("rst_empty", 32'(qc.empty), 1);
    chk("rst_full", 32'(qc.full), 0);
    chk("rst_tc_err", 32'(qc.tc_err), 1);
    rst_n = 1'b1;
    qc.tcount = 2'd2;
    @(negedge clk);
    qc.sens_back = 1'b1;
    repeat (6) @(negedge clk);
    qc.sens_back = 1'b0;
    repeat (2) @(negedge clk);
    chk("lat_edge2", 32'(qc.pcount), 0);
    @(negedge clk);
    chk("lat_edge3", 32'(qc.pcount), 1);
    chk("empty_drop", 32'(qc.empty), 0);
    repeat (3) @(negedge clk);
    pulse(1, 0, 6);
    pulse(1, 0, 6);
    chk("three_entries", 32'(qc.pcount), 3);
    chk("tc_out_2", 32'(qc.tc_out), 2);
    chk("tc_err_0", 32'(qc.tc_err), 0);
    pulse(1, 0, 3);
    chk("glitch_3cyc", 32'(qc.pcount), 3);
    pulse(1, 0, 4);
    chk("min_blk_4cyc", 32'(qc.pcount), 4);
    pulse(0, 1, 6);
    chk("exit", 32'(qc.pcount), 3);
    pulse(1, 1, 6);
    chk("both_at_3", 32'(qc.pcount), 3);
    repeat (4) pulse(1, 0, 6);
    chk("fill_7", 32'(qc.pcount), 7);
    chk("full_7", 32'(qc.full), 1);
    o = n_ovf;
    pulse(1, 0, 6);
    chk("ovf_hold", 32'(qc.pcount), 7);
    chk("ovf_once", 32'(n_ovf - o), 1);
    repeat (7) pulse(0, 1, 6);
    chk("drain_0", 32'(qc.pcount), 0);
    u = n_unf;
    pulse(0, 1, 6);
    chk("unf_hold", 32'(qc.pcount), 0);
    chk("unf_once", 32'(n_unf - u), 1);
    pulse(1, 1, 6);
    chk("both_at_0", 32'(qc.pcount), 0);
    chk("both_no_unf", 32'(n_unf - u), 1);
    qc.tcount = 2'd0;
    @(negedge clk);
    chk("tc_err_1", 32'(qc.tc_err), 1);
    pulse(1, 0, 6);
    chk("count_tc_err", 32'(qc.pcount), 1);
    qc.tcount = 2'd1;
    qc.sens_back = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst", 32'(qc.pcount), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    qc.sens_back = 1'b0;
    repeat (6) @(negedge clk);
    chk("short_after_rst", 32'(qc.pcount), 0);
    pulse(1, 0, 6);
    chk("full_after_rst", 32'(qc.pcount), 1);
    hb = 0;
    hf = 0;
    for (int c = 0; c < 600; c++) begin
      if (hb == 0) begin qc.sens_back = ~qc.sens_back; hb = $urandom_range(1, 8); end
      if (hf == 0) begin qc.sens_front = ~qc.sens_front; hf = $urandom_range(1, 9); end
      if ($urandom_range(0, 39) == 0) qc.tcount = 2'($urandom);
      hb--;
      hf--;
      @(negedge clk);
    end
    qc.sens_back = 1'b0;
    qc.sens_front = 1'b0;
    repeat (8) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/queue_counter.md
# queue_counter

Upstream occupancy stage of the bank queue manager. Watches the entry (back) and exit (front) photocell sensors, rejects glitches, and counts complete passes. It maintains the registered customer count `pcount` and teller count `tc_out` that address the downstream wait-time lookup, plus full/empty status and error flags.

## Interface
Parameters:
- `PC_W`, 3: count width; `pcount` saturates at `2**PC_W-1` (7).
- `MIN_BLK`, 4: minimum consecutive synchronized-high cycles for a sensor blockage to count as a pass (legal range ≥1).

Ports:
- `clk`  in  1  system clock; every flop is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `sens_back`  in  1  entry photocell, asynchronous, high while blocked.
- `sens_front`  in  1  exit photocell, asynchronous, high while blocked.
- `tcount`  in  2  number of open teller windows; quasi-static.
- `pcount`  out  PC_W  customers in queue; feeds the wait-time lookup address.
- `tc_out`  out  2  registered `tcount`, aligned with `pcount`.
- `full`  out  1  `pcount == 7`.
- `empty`  out  1  `pcount == 0`.
- `ovf_err`  out  1  one-cycle pulse: an entry was rejected because the queue was full.
- `unf_err`  out  1  one-cycle pulse: an exit was rejected because the queue was empty.
- `tc_err`  out  1  level: registered `tcount == 0`, which is an illegal window count.

## Operation
- Each sensor passes through a 2-flop synchronizer (`s1`, `s2`), then drives its own pass-detect FSM.
- Pass-detect FSM states and transitions:
  - IDLE: `s2`=1 → BLOCKED, `blk_cnt`=1.
  - BLOCKED: `s2`=1 → `blk_cnt`++; when `blk_cnt` reaches MIN_BLK → VALID. `s2`=0 before that → IDLE with no pulse (glitch rejected).
  - VALID: holds while `s2`=1. `s2`=0 → combinational `pass` pulse for one cycle, then IDLE.
- `blk_cnt` is wide enough for MIN_BLK and saturates. No pulse is possible without a full high→low blockage.
- Counter update, evaluated once per cycle:
  - Entry pass and exit pass in the same cycle → `pcount` unchanged, no error, even when full or empty.
  - Entry pass only: `pcount`<7 → +1. At 7 → unchanged, `ovf_err`=1 for one cycle.
  - Exit pass only: `pcount`>0 → −1. At 0 → unchanged, `unf_err`=1 for one cycle.
- The count never wraps. `full` and `empty` are registered with `pcount`, so they always agree with it.
- `tc_out` and `tc_err` register `tcount` every cycle. `tc_err` does not block counting.
- Reset values: `pcount`=0, `tc_out`=0, `full`=0, `empty`=1, `ovf_err`=0, `unf_err`=0, `tc_err`=1. Both FSMs return to IDLE, `blk_cnt`=0, and synchronizers clear to 0.
- Reset asserted mid-blockage discards that pass. After release, a sensor that is still high is treated as a new blockage.

## Timing
- Raw sensor first sampled low at edge E1: `s2` goes low at E2, `pass` is high during the cycle after E2, and `pcount`, `full`, `empty` and the error pulses update at E3. Latency from falling sensor to count is 3 edges.
- Raw sensor first sampled high at E1: `s2` goes high at E2. The blockage becomes VALID once `s2` has been high for MIN_BLK edges.
- `tcount` change to `tc_out`: 1 edge. `pcount` and `tc_out` are both registered, so the downstream lookup sees a stable address.
- Back-to-back passes on one sensor need at least 1 low cycle between blockages (VALID→IDLE→BLOCKED). At most one pass per sensor every MIN_BLK+1 cycles.

## Structure
- Shared `sbqm_pkg`: `PC_W`, `TC_W`=2, `MAX_PC`=7, and the pass-detect state enum (IDLE, BLOCKED, VALID). The downstream lookup uses the same widths.
- Sub-module `sensor_pass_detect` (synchronizer + FSM + `blk_cnt`), instantiated twice: once for back, once for front.
- The top level contains only the counter, flags and the `tcount` register.

## Test plan
- Reset, then `tcount`=2, then 3 entry blockages of 6 cycles each → `pcount` steps 1,2,3, each 3 edges after the sensor falls. `empty` drops after the first pass. `tc_out`=2, `tc_err`=0.
- With MIN_BLK=4: a 3-cycle `sens_back` pulse leaves `pcount` unchanged; a 4-cycle pulse increments it.
- Fill to 7 (`full`=1), then an 8th entry → `pcount` stays 7 and `ovf_err` is high for exactly 1 cycle.
- From `pcount`=0, an exit pass → `pcount` stays 0 and `unf_err` pulses. Entry and exit falling on the same cycle at `pcount`=3 → stays 3, no errors.
- `tcount`=0 → `tc_err`=1 after 1 edge, and counting continues. Assert `rst_n` mid-blockage and release with the sensor still high → `pcount`=0, and a pass is counted only after a full new blockage that meets MIN_BLK.
